// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard for in-order issue.
// Tracks outstanding writes and refuses issue on RAW/WAW hazards.
module reg_file_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic [AW-1:0]   iRs1Addr,
    input  logic [AW-1:0]   iRs2Addr,
    output logic [XLEN-1:0] oRs1Data,
    output logic [XLEN-1:0] oRs2Data,
    input  logic            iWrEn,
    input  logic [AW-1:0]   iWrAddr,
    input  logic [XLEN-1:0] iWrData,
    input  logic            iIssue,
    input  logic [AW-1:0]   iIssueRd,
    input  logic            iFlush,
    output logic            oRs1Busy,
    output logic            oRs2Busy,
    output logic            oStall,
    output logic [AW:0]     oBusyCnt
);

    localparam int unsigned NREG = 2 ** AW;
    localparam bit          Fwd  = (BYPASS != 0);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;

    logic wr_live;
    logic rs1_fwd, rs2_fwd;
    logic rs1_busy, rs2_busy, rd_busy;
    logic accept;

    assign wr_live = iWrEn && (iWrAddr != '0);
    assign rs1_fwd = Fwd && wr_live && (iWrAddr == iRs1Addr);
    assign rs2_fwd = Fwd && wr_live && (iWrAddr == iRs2Addr);

    always_comb begin
        oRs1Data = '0;
        oRs2Data = '0;
        if (rs1_fwd) begin
            oRs1Data = iWrData;
        end else if (iRs1Addr != '0) begin
            oRs1Data = regs_q[iRs1Addr];
        end
        if (rs2_fwd) begin
            oRs2Data = iWrData;
        end else if (iRs2Addr != '0) begin
            oRs2Data = regs_q[iRs2Addr];
        end
    end

    // A same-cycle write to the register retires its producer, so it no longer blocks.
    assign rs1_busy = (iRs1Addr != '0) && busy_q[iRs1Addr] && !rs1_fwd;
    assign rs2_busy = (iRs2Addr != '0) && busy_q[iRs2Addr] && !rs2_fwd;
    assign rd_busy  = (iIssueRd != '0) && busy_q[iIssueRd]
                      && !(Fwd && wr_live && (iWrAddr == iIssueRd));

    assign oRs1Busy = rs1_busy;
    assign oRs2Busy = rs2_busy;
    assign oStall   = iIssue && (rs1_busy || rs2_busy || rd_busy);
    assign accept   = iIssue && !oStall;
    assign oBusyCnt = busy_cnt_q;

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[iWrAddr] = iWrData;
        end
    end

    // Clear-on-write precedes set-on-issue so a new producer wins the same address.
    always_comb begin
        busy_d = busy_q;
        if (iWrEn) begin
            busy_d[iWrAddr] = 1'b0;
        end
        if (accept && (iIssueRd != '0)) begin
            busy_d[iIssueRd] = 1'b1;
        end
        if (iFlush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one forwarding instance and one without,
// driven from shared inputs and checked against hand-computed values.
module tb_reg_file_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [XLEN-1:0] wr_data;
    logic            wr_en, issue, flush;

    logic [XLEN-1:0] rs1_data, rs2_data, rs1_data_nb, rs2_data_nb;
    logic            rs1_busy, rs2_busy, stall, rs1_busy_nb, rs2_busy_nb, stall_nb;
    logic [AW:0]     busy_cnt, busy_cnt_nb;

    int n_vec;
    int n_err;

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut (
        .iClk     (clk),
        .iRstN    (rst_n),
        .iRs1Addr (rs1_addr),
        .iRs2Addr (rs2_addr),
        .oRs1Data (rs1_data),
        .oRs2Data (rs2_data),
        .iWrEn    (wr_en),
        .iWrAddr  (wr_addr),
        .iWrData  (wr_data),
        .iIssue   (issue),
        .iIssueRd (issue_rd),
        .iFlush   (flush),
        .oRs1Busy (rs1_busy),
        .oRs2Busy (rs2_busy),
        .oStall   (stall),
        .oBusyCnt (busy_cnt)
    );

    reg_file_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) dut_nb (
        .iClk     (clk),
        .iRstN    (rst_n),
        .iRs1Addr (rs1_addr),
        .iRs2Addr (rs2_addr),
        .oRs1Data (rs1_data_nb),
        .oRs2Data (rs2_data_nb),
        .iWrEn    (wr_en),
        .iWrAddr  (wr_addr),
        .iWrData  (wr_data),
        .iIssue   (issue),
        .iIssueRd (issue_rd),
        .iFlush   (flush),
        .oRs1Busy (rs1_busy_nb),
        .oRs2Busy (rs2_busy_nb),
        .oStall   (stall_nb),
        .oBusyCnt (busy_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        issue_rd = '0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        // After reset: every register reads zero, nothing busy, no stall.
        for (int a = 0; a < 32; a++) begin
            rs1_addr = AW'(a);
            rs2_addr = AW'(31 - a);
            #1;
            check("rst_rs1", rs1_data, 0);
            check("rst_rs2", rs2_data, 0);
        end
        check("rst_cnt", busy_cnt, 0);
        issue = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("rst_stall", stall, 0);
        check("rst_busy", rs1_busy, 0);
        idle();

        // Write x5, read it back next cycle.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        idle();
        rs1_addr = 5'd5;
        #1;
        check("x5_rd", rs1_data, 32'hDEADBEEF);
        check("x5_rd_nb", rs1_data_nb, 32'hDEADBEEF);

        // Write to x0 is dropped and never forwarded.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs1_addr = 5'd0;
        #1;
        check("x0_fwd", rs1_data, 0);
        step();
        idle();
        #1;
        check("x0_rd", rs1_data, 0);

        // Same-cycle forwarding vs. none.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rs2_addr = 5'd7;
        #1;
        check("x7_fwd", rs2_data, 32'hA5A5A5A5);
        check("x7_nofwd", rs2_data_nb, 0);
        step();
        wr_en = 1'b0;
        #1;
        check("x7_rd_nb", rs2_data_nb, 32'hA5A5A5A5);
        idle();

        // RAW hazard on x3.
        issue = 1'b1; issue_rd = 5'd3;
        #1;
        check("iss3_stall", stall, 0);
        step();
        issue_rd = 5'd8; rs1_addr = 5'd3;
        #1;
        check("raw_busy", rs1_busy, 1);
        check("raw_stall", stall, 1);
        check("raw_cnt", busy_cnt, 1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        check("wb_stall", stall, 0);
        check("wb_busy", rs1_busy, 0);
        check("wb_fwd", rs1_data, 32'h33);
        check("wb_stall_nb", stall_nb, 1);
        step();
        idle();
        rs1_addr = 5'd3;
        #1;
        check("wb_clr", rs1_busy, 0);
        check("wb_clr_nb", rs1_busy_nb, 0);
        check("wb_cnt", busy_cnt, 1);
        check("wb_cnt_nb", busy_cnt_nb, 0);
        idle();

        // Issue and writeback to x4 in the same cycle: new producer wins.
        issue = 1'b1; issue_rd = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        #1;
        check("iw4_stall", stall, 0);
        step();
        idle();
        rs1_addr = 5'd4;
        #1;
        check("iw4_busy", rs1_busy, 1);
        check("iw4_busy_nb", rs1_busy_nb, 1);
        check("iw4_cnt", busy_cnt, 2);
        check("iw4_cnt_nb", busy_cnt_nb, 1);
        check("iw4_data", rs1_data_nb, 32'h44);

        // WAW hazard on x4, then issue to x0 leaves the count alone.
        issue = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd0;
        #1;
        check("waw_stall", stall, 1);
        issue_rd = 5'd0;
        #1;
        check("iss0_stall", stall, 0);
        step();
        idle();
        #1;
        check("iss0_cnt", busy_cnt, 2);

        // Flush overrides a simultaneous issue.
        flush = 1'b1; issue = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        check("fl1_cnt", busy_cnt, 0);
        check("fl1_cnt_nb", busy_cnt_nb, 0);

        issue = 1'b1;
        issue_rd = 5'd1; step();
        issue_rd = 5'd2; step();
        issue_rd = 5'd6; step();
        idle();
        check("iss3_cnt", busy_cnt, 3);
        check("iss3_cnt_nb", busy_cnt_nb, 3);
        flush = 1'b1;
        step();
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        #1;
        check("fl2_cnt", busy_cnt, 0);
        check("fl2_x5", rs1_data, 32'hDEADBEEF);
        check("fl2_x7", rs2_data, 32'hA5A5A5A5);
        idle();

        // Reset mid-operation discards busy marks and ignores that cycle's traffic.
        issue = 1'b1; issue_rd = 5'd10;
        step();
        issue = 1'b0;
        check("pre_rst_cnt", busy_cnt, 1);
        rst_n = 1'b0;
        issue = 1'b1; issue_rd = 5'd11; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hFFFF;
        step();
        rst_n = 1'b1;
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd12;
        #1;
        check("rst2_cnt", busy_cnt, 0);
        check("rst2_x5", rs1_data, 0);
        check("rst2_x12", rs2_data, 0);
        issue = 1'b1; issue_rd = 5'd10; rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        check("rst2_stall", stall, 0);
        check("rst2_busy", rs1_busy, 0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter AW, default 5, meaning register address width; register count NREG = 2**AW.
REQ-003 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 SHALL have port iClk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port iRstN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports iRs1Addr, iRs2Addr  input  AW  read port addresses.
REQ-007 SHALL have ports oRs1Data, oRs2Data  output  XLEN  read port data.
REQ-008 SHALL have ports iWrEn  input  1, iWrAddr  input  AW, iWrData  input  XLEN  writeback port.
REQ-009 SHALL have ports iIssue  input  1, iIssueRd  input  AW  issue request and its destination register.
REQ-010 SHALL have port iFlush  input  1  clears all pending-write (busy) marks.
REQ-011 SHALL have ports oRs1Busy, oRs2Busy  output  1  source register has an outstanding write.
REQ-012 SHALL have port oStall  output  1  issue request is refused this cycle.
REQ-013 SHALL have port oBusyCnt  output  AW+1  registered count of busy registers.

Function
REQ-014 SHALL hold NREG data registers of XLEN bits and NREG busy bits.
REQ-015 Register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-016 Reads SHALL be combinational: oRsNData = reg[iRsNAddr], zero-latency.
REQ-017 With BYPASS=1, if iWrEn=1 and iWrAddr==iRsNAddr!=0, oRsNData SHALL equal iWrData in the same cycle.
REQ-018 Write SHALL update reg[iWrAddr] <= iWrData at the edge when iWrEn=1 and iWrAddr!=0.
REQ-019 Raw busy SHALL be busy[a] excluding a==0; with BYPASS=1 a same-cycle write to a SHALL also mask it.
REQ-020 oRsNBusy SHALL equal the raw busy of iRsNAddr per REQ-019.
REQ-021 oStall SHALL be iIssue & (oRs1Busy | oRs2Busy | raw busy of iIssueRd) (RAW and WAW hazards).
REQ-022 Issue SHALL be accepted when iIssue=1 and oStall=0; accepted issue with iIssueRd!=0 sets busy[iIssueRd] at the edge.
REQ-023 A write with iWrEn=1 SHALL clear busy[iWrAddr] at the edge.
REQ-024 Simultaneous accepted issue and write to the same address: busy SHALL end set (new producer wins).
REQ-025 iFlush=1 SHALL clear all busy bits at the edge, overriding issue set; register data and the write SHALL still proceed.
REQ-026 oBusyCnt SHALL equal the population count of busy bits after each edge (one-cycle latency); never exceeds NREG-1.
REQ-027 Write to a non-busy register SHALL update data and leave busy unchanged (no error).
REQ-028 Out-of-range states are impossible: all AW-bit addresses are valid.

Reset
REQ-029 When iRstN=0 at an edge, all registers SHALL become 0, all busy bits 0, oBusyCnt 0; issue and write that cycle SHALL be ignored.
REQ-030 Reset mid-operation SHALL discard all pending-write marks; after reset oStall=0 for any request.
REQ-031 Outputs after reset: oRsNData=0 (BYPASS aside), oRsNBusy=0, oStall=0.

Verification
REQ-032 Reset then read all addresses -> every oRsNData=0, oBusyCnt=0.
REQ-033 Write x5=0xDEADBEEF, next cycle read RS1=5 -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-034 BYPASS=1: write x7=0xA5A5A5A5 and RS2=7 same cycle -> oRs2Data=0xA5A5A5A5 that cycle; BYPASS=0 -> old value.
REQ-035 Issue rd=3, next cycle issue with RS1=3 -> oRs1Busy=1, oStall=1, oBusyCnt=1; write x3 -> same-cycle (BYPASS=1) oStall=0, busy cleared after edge.
REQ-036 Issue rd=4 and write x4 in same cycle -> busy[4]=1 after edge; issue rd=0 -> oBusyCnt unchanged.
REQ-037 Issue rd=1,2,6 then iFlush=1 -> oBusyCnt 3 then 0, register data unchanged; iRstN=0 with busy set -> all cleared next edge.
